// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the register-file write-port
// arbiter slice (wb_arb, wb_arb_fifo, wb_arb_if).
//   W_REGF / W_DATA  : register index and data widths
//   NUM_REGS         : number of architectural registers (width of busy_mask)
//   WB_ARB_DEPTH     : out-of-band buffer depth
//   wb_arb_entry_t   : one buffered out-of-band write {live, regf, data}
package wb_arb_pkg;

   localparam int W_REGF       = 5;
   localparam int W_DATA       = 32;
   localparam int NUM_REGS     = 1 << W_REGF;
   localparam int WB_ARB_DEPTH = 2;
   localparam int WB_ARB_CNT_W = $clog2(WB_ARB_DEPTH + 1);

   typedef struct packed {
      logic              live;
      logic [W_REGF-1:0] regf;
      logic [W_DATA-1:0] data;
   } wb_arb_entry_t;

   function automatic logic [NUM_REGS-1:0] regf_onehot(input logic [W_REGF-1:0] r);
      regf_onehot = NUM_REGS'(1) << r;
   endfunction

endpackage

// File: rtl/wb_arb_if.sv
// wb_arb_if: bundle of the arbiter's bus-side signals.
//   pipe_*    : in-order writeback write (priority, never back-pressured)
//   aux_*     : out-of-band valid/ready write request
//   rd_*      : registered write port to the register file
//   busy_mask : registers targeted by live buffered writes
//   stall_req : starvation bubble request to the pipeline
// Modports: master = pipeline/requester/register-file side, slave = arbiter.
interface wb_arb_if;
   import wb_arb_pkg::*;

   logic                pipe_we;
   logic [W_REGF-1:0]   pipe_regf;
   logic [W_DATA-1:0]   pipe_data;
   logic                aux_valid;
   logic                aux_ready;
   logic [W_REGF-1:0]   aux_regf;
   logic [W_DATA-1:0]   aux_data;
   logic                rd_we;
   logic [W_REGF-1:0]   rd_regf;
   logic [W_DATA-1:0]   rd_data;
   logic [NUM_REGS-1:0] busy_mask;
   logic                stall_req;

   modport master (
      output pipe_we, pipe_regf, pipe_data,
      output aux_valid, aux_regf, aux_data,
      input  aux_ready,
      input  rd_we, rd_regf, rd_data,
      input  busy_mask, stall_req
   );

   modport slave (
      input  pipe_we, pipe_regf, pipe_data,
      input  aux_valid, aux_regf, aux_data,
      output aux_ready,
      output rd_we, rd_regf, rd_data,
      output busy_mask, stall_req
   );

endinterface

// File: rtl/wb_arb_fifo.sv
// wb_arb_fifo: small shift FIFO holding out-of-band writes.
//   clk, rst   : clock, synchronous active-high reset (drops all entries)
//   push       : store push_entry at the tail (caller guarantees space)
//   push_entry : entry to store
//   pop        : drop the head entry
//   kill_en    : clear live on every entry present this cycle whose regf
//                matches kill_regf (the incoming push is never killed)
//   kill_regf  : register index to kill
//   head       : head entry (valid when count != 0)
//   count      : number of entries held
//   live_mask  : one-hot OR of regf over live entries
module wb_arb_fifo
   import wb_arb_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  wb_arb_entry_t           push_entry,
   input  logic                    pop,
   input  logic                    kill_en,
   input  logic [W_REGF-1:0]       kill_regf,
   output wb_arb_entry_t           head,
   output logic [WB_ARB_CNT_W-1:0] count,
   output logic [NUM_REGS-1:0]     live_mask
);

   localparam logic [WB_ARB_CNT_W-1:0] CNT_ONE = WB_ARB_CNT_W'(1);

   wb_arb_entry_t           ent      [WB_ARB_DEPTH];
   wb_arb_entry_t           ent_kill [WB_ARB_DEPTH];
   wb_arb_entry_t           ent_nxt  [WB_ARB_DEPTH];
   logic [WB_ARB_CNT_W-1:0] cnt;
   logic [WB_ARB_CNT_W-1:0] cnt_nxt;

   // Kill is applied to the entries as they stand at the start of the cycle,
   // before the pop shift and the push, so a same-cycle push survives.
   always_comb begin
      for (int i = 0; i < WB_ARB_DEPTH; i++) begin
         ent_kill[i] = ent[i];
         if (kill_en && (ent[i].regf == kill_regf)) begin
            ent_kill[i].live = 1'b0;
         end
      end
   end

   always_comb begin
      ent_nxt = ent_kill;
      cnt_nxt = cnt;
      if (pop && (cnt != '0)) begin
         for (int i = 0; i < WB_ARB_DEPTH - 1; i++) begin
            ent_nxt[i] = ent_kill[i+1];
         end
         ent_nxt[WB_ARB_DEPTH-1].live = 1'b0;
         cnt_nxt = cnt - CNT_ONE;
      end
      if (push && (int'(cnt_nxt) < WB_ARB_DEPTH)) begin
         for (int i = 0; i < WB_ARB_DEPTH; i++) begin
            if (i == int'(cnt_nxt)) begin
               ent_nxt[i] = push_entry;
            end
         end
         cnt_nxt = cnt_nxt + CNT_ONE;
      end
   end

   // Only the live flags need a reset value; stale regf/data are masked by cnt.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         for (int i = 0; i < WB_ARB_DEPTH; i++) begin
            ent[i].live <= 1'b0;
         end
      end else begin
         cnt <= cnt_nxt;
         for (int i = 0; i < WB_ARB_DEPTH; i++) begin
            ent[i] <= ent_nxt[i];
         end
      end
   end

   always_comb begin
      live_mask = '0;
      for (int i = 0; i < WB_ARB_DEPTH; i++) begin
         if ((i < int'(cnt)) && ent[i].live) begin
            live_mask = live_mask | regf_onehot(ent[i].regf);
         end
      end
   end

   assign head  = ent[0];
   assign count = cnt;

endmodule

// File: rtl/wb_arb.sv
// wb_arb: shares the single GPR write port between the in-order writeback
// (priority, never stalled) and one out-of-band requester buffered in a
// 2-entry FIFO. Exports a pending-register mask and a starvation stall.
//   MAX_WAIT : cycles a live buffered head may wait before stall_req (1..15)
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_arb_if.slave -- pipe_*, aux_* handshake, rd_* write port,
//              busy_mask, stall_req
module wb_arb
   import wb_arb_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic    clk,
   input  logic    rst,
   wb_arb_if.slave bus
);

   localparam logic [3:0] MAX_W    = 4'(MAX_WAIT);
   localparam logic [3:0] WAIT_ONE = 4'd1;

   wb_arb_entry_t           head;
   wb_arb_entry_t           push_entry;
   logic [WB_ARB_CNT_W-1:0] count;
   logic [NUM_REGS-1:0]     live_mask;

   logic eff_pipe;
   logic head_vld;
   logic head_live;
   logic pop;
   logic push;
   logic aux_ready;

   logic              wr_we_p0;
   logic [W_REGF-1:0] wr_regf_p0;
   logic [W_DATA-1:0] wr_data_p0;

   logic              rd_we_p1;
   logic [W_REGF-1:0] rd_regf_p1;
   logic [W_DATA-1:0] rd_data_p1;
   logic              stall_p1;
   logic [3:0]        wait_cnt;

   // A pipe write to $0 is architecturally a no-op and never wins the port.
   assign eff_pipe  = bus.pipe_we && (bus.pipe_regf != '0);
   assign head_vld  = (count != '0);
   assign head_live = head_vld && head.live;
   // The head leaves whenever the pipe is not using the port; dead heads
   // leave without a write.
   assign pop       = head_vld && !eff_pipe;

   // Ready looks at registered occupancy only, so a full buffer refuses even
   // when it pops this cycle; this keeps aux_* off any combinational path.
   assign aux_ready  = (int'(count) < WB_ARB_DEPTH);
   assign push       = bus.aux_valid && aux_ready;
   assign push_entry = '{live: (bus.aux_regf != '0),
                         regf: bus.aux_regf,
                         data: bus.aux_data};

   wb_arb_fifo u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .kill_en    (eff_pipe),
      .kill_regf  (bus.pipe_regf),
      .head       (head),
      .count      (count),
      .live_mask  (live_mask)
   );

   // ---- stage p0: port selection ----
   always_comb begin
      wr_we_p0   = 1'b0;
      wr_regf_p0 = '0;
      wr_data_p0 = '0;
      if (eff_pipe) begin
         wr_we_p0   = 1'b1;
         wr_regf_p0 = bus.pipe_regf;
         wr_data_p0 = bus.pipe_data;
      end else if (head_live) begin
         wr_we_p0   = 1'b1;
         wr_regf_p0 = head.regf;
         wr_data_p0 = head.data;
      end
   end

   // ---- stage p1: registered write port and starvation tracking ----
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_we_p1   <= 1'b0;
         rd_regf_p1 <= '0;
         rd_data_p1 <= '0;
         wait_cnt   <= '0;
         stall_p1   <= 1'b0;
      end else begin
         rd_we_p1 <= wr_we_p0;
         if (wr_we_p0) begin
            rd_regf_p1 <= wr_regf_p0;
            rd_data_p1 <= wr_data_p0;
         end
         // A dead head blocked by the pipe keeps the count it had.
         if (!head_vld || pop) begin
            wait_cnt <= '0;
         end else if (head_live && (wait_cnt != MAX_W)) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
         end
         stall_p1 <= (wait_cnt == MAX_W);
      end
   end

   assign bus.aux_ready = aux_ready;
   assign bus.rd_we     = rd_we_p1;
   assign bus.rd_regf   = rd_regf_p1;
   assign bus.rd_data   = rd_data_p1;
   assign bus.busy_mask = live_mask;
   assign bus.stall_req = stall_p1;

endmodule
